// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC control path.
// RV_MC_CTRL_MUL_EN selects the multi-cycle mul decode.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2,
    ALU_MUL   = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_MUL   = 6'b011000;

`ifdef RV_MC_CTRL_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic    legal;
    logic    is_r;
    logic    is_lw;
    logic    is_sw;
    logic    is_beq;
    logic    is_j;
    logic    alu_src;
    alu_op_e alu_op;
  } dec_t;

endpackage

// File: rtl/rv_ctrl_dec.sv
// Combinational op/funct decode into EXEC-stage controls.
// Mul recognition follows RV_MC_CTRL_MUL_EN (via rv_ctrl_pkg::MUL_EN).
module rv_ctrl_dec
  import rv_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o.alu_op = ALU_ADD;
    case (op_i)
      OP_RTYPE: begin
        dec_o.legal  = 1'b1;
        dec_o.is_r   = 1'b1;
        dec_o.alu_op = (MUL_EN && funct_i == FN_MUL) ? ALU_MUL : ALU_FUNCT;
      end
      OP_ADDI: begin
        dec_o.legal   = 1'b1;
        dec_o.alu_src = 1'b1;
      end
      OP_LW: begin
        dec_o.legal   = 1'b1;
        dec_o.is_lw   = 1'b1;
        dec_o.alu_src = 1'b1;
      end
      OP_SW: begin
        dec_o.legal   = 1'b1;
        dec_o.is_sw   = 1'b1;
        dec_o.alu_src = 1'b1;
      end
      OP_BEQ: begin
        dec_o.legal  = 1'b1;
        dec_o.is_beq = 1'b1;
        dec_o.alu_op = ALU_SUB;
      end
      OP_J: begin
        dec_o.legal = 1'b1;
        dec_o.is_j  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback sequencing and strobes.
// RV_MC_CTRL_MUL_EN adds a down-counter that stretches EXEC for mul.
module rv_mc_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_we_o,
  output logic       ir_we_o,
  output logic       reg_we_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       alu_src_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] alu_op_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
    $error("rv_mc_ctrl: MUL_CYCLES must be in 2..15");
  end

  state_e state_q, state_d;
  dec_t   dec;

`ifdef RV_MC_CTRL_MUL_EN
  logic [3:0] cnt_q, cnt_d;
`endif

  rv_ctrl_dec u_dec (
    .op_i    (op_i),
    .funct_i (funct_i),
    .dec_o   (dec)
  );

  // Strobes depend on the current state plus mem_ready_i/zero_i in the same cycle.
  always_comb begin
    state_d      = state_q;
`ifdef RV_MC_CTRL_MUL_EN
    cnt_d        = cnt_q;
`endif
    pc_we_o      = 1'b0;
    ir_we_o      = 1'b0;
    reg_we_o     = 1'b0;
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    alu_src_o    = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    pc_src_o     = PC_PLUS4;
    alu_op_o     = ALU_ADD;
    err_o        = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
`ifdef RV_MC_CTRL_MUL_EN
        cnt_d = 4'(MUL_CYCLES - 1);
`endif
        if (dec.legal) state_d = S_EXEC;
        else begin
          err_o   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_o = dec.alu_src;
        alu_op_o  = dec.alu_op;
        if (dec.is_beq) begin
          if (zero_i) begin
            pc_we_o  = 1'b1;
            pc_src_o = PC_BRANCH;
          end
          state_d = S_FETCH;
        end else if (dec.is_j) begin
          pc_we_o  = 1'b1;
          pc_src_o = PC_JUMP;
          state_d  = S_FETCH;
        end else if (dec.is_lw || dec.is_sw) state_d = S_MEM;
`ifdef RV_MC_CTRL_MUL_EN
        else if (dec.alu_op == ALU_MUL && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
`endif
        else state_d = S_WB;
      end
      S_MEM: begin
        alu_src_o = dec.alu_src;
        mem_rd_o  = dec.is_lw;
        mem_wr_o  = dec.is_sw;
        if (mem_ready_i) state_d = dec.is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        alu_src_o    = dec.alu_src;
        reg_we_o     = 1'b1;
        reg_dst_o    = dec.is_r;
        mem_to_reg_o = dec.is_lw;
        state_d      = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
`ifdef RV_MC_CTRL_MUL_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef RV_MC_CTRL_MUL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign state_o = state_q;

endmodule
